lc3_regfile_sel: RTL

- Parametrised LC-3 general-purpose register file with integrated SR1/SR2/DR address selection from the instruction register.
- Generalises the stand-alone SR1 select mux: it adds a DR select (IR[11:9] or link register R7), configurable data width and register count, and write-through bypass.
- Optionally registers the read outputs for a pipelined datapath.
- Sits between IR/BUS and the ALU/ADDR-adder operand inputs in the LC-3 datapath.

---
 rtl/lc3_regfile_sel.sv | 100 ++++++++++
 1 files changed

// File: rtl/lc3_regfile_sel.sv
// lc3_regfile_sel
// LC-3 general-purpose register file with the SR1/SR2/DR address selection
// folded in. Register indices come straight from the instruction register:
//   SR1 = SR1MUX ? IR[11:9] : IR[8:6]
//   SR2 = IR[2:0]
//   DR  = DRMUX  ? NREG-1 (R7, link register) : IR[11:9]
// Only the AW low bits of each 3-bit field are used, so a smaller file
// aliases the upper register names onto the lower ones.
//
// Read modes (READ_REG):
//   0 : SR1_OUT/SR2_OUT are combinational, with write-through bypass so an
//       operand being written this cycle is seen as D_in immediately.
//   1 : SR1_OUT/SR2_OUT are registered. Each edge captures the value the
//       selected register holds after that same edge's write.
//
// Ports:
//   Clk      in   system clock, rising edge active
//   Reset    in   asynchronous active-low clear of all state
//   IR       in   current instruction (IR_W bits, IR_W >= 12)
//   SR1MUX   in   SR1 field select
//   DRMUX    in   DR select (IR[11:9] or link register)
//   LD_REG   in   write enable for reg[DR]
//   D_in     in   write data
//   SR1_OUT  out  SR1 operand
//   SR2_OUT  out  SR2 operand
//   SR1_IDX  out  resolved SR1 index (combinational)
//   DR_IDX   out  resolved DR index (combinational)
module lc3_regfile_sel #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 8,
  parameter int IR_W     = 16,
  parameter int READ_REG = 0,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [IR_W-1:0]   IR,
  input  logic              SR1MUX,
  input  logic              DRMUX,
  input  logic              LD_REG,
  input  logic [DATA_W-1:0] D_in,
  output logic [DATA_W-1:0] SR1_OUT,
  output logic [DATA_W-1:0] SR2_OUT,
  output logic [AW-1:0]     SR1_IDX,
  output logic [AW-1:0]     DR_IDX
);

  logic [DATA_W-1:0] regs [NREG];
  logic [AW-1:0]     sr1_idx;
  logic [AW-1:0]     sr2_idx;
  logic [AW-1:0]     dr_idx;
  logic              wr_en;

  // Only a few IR bits select registers; the rest (opcode, immediates,
  // truncated field bits) are intentionally ignored here.
  logic unused_ir;
  assign unused_ir = ^IR;

  assign sr1_idx = SR1MUX ? IR[9 +: AW] : IR[6 +: AW];
  assign sr2_idx = IR[0 +: AW];
  assign dr_idx  = DRMUX ? AW'(NREG - 1) : IR[9 +: AW];

  // A write only happens out of reset; the bypass uses the same qualifier so
  // the operands never show D_in while the file is being held clear.
  assign wr_en = LD_REG & Reset;

  assign SR1_IDX = sr1_idx;
  assign DR_IDX  = dr_idx;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (LD_REG) begin
      regs[dr_idx] <= D_in;
    end
  end

  generate
    if (READ_REG == 0) begin : g_comb_read
      // Write-through bypass, independent per operand.
      assign SR1_OUT = (wr_en && (sr1_idx == dr_idx)) ? D_in : regs[sr1_idx];
      assign SR2_OUT = (wr_en && (sr2_idx == dr_idx)) ? D_in : regs[sr2_idx];
    end else begin : g_reg_read
      // Forward D_in when this edge writes the register being captured, so
      // the output reflects the post-write contents rather than stale data.
      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          SR1_OUT <= '0;
          SR2_OUT <= '0;
        end else begin
          SR1_OUT <= (LD_REG && (sr1_idx == dr_idx)) ? D_in : regs[sr1_idx];
          SR2_OUT <= (LD_REG && (sr2_idx == dr_idx)) ? D_in : regs[sr2_idx];
        end
      end
    end
  endgenerate

endmodule
